// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter and its round-robin selector.
// Contents:
//   arb_state_e - arbiter state encoding (StIdle = 1'b0, StBurst = 1'b1)
//   CNT_W       - width of the beat and stall counters
//   clog2       - index width helper; never returns less than 1
package fifo_arb_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } arb_state_e;

  localparam int unsigned CNT_W = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Searches upward from ptr+1 (mod NUM_REQ) and returns the first set request.
// Ports:
//   req   - request vector
//   ptr   - index of the last winner (lowest priority)
//   found - any request set
//   index - winning requester, 0 when nothing is found
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  always_comb begin
    int unsigned cand;
    found = 1'b0;
    index = '0;
    cand  = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        index = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between NUM_REQ producers.
// Ownership is granted per burst; the owner's beats are passed to the FIFO
// only while the FIFO is not full.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   req           - per-requester beat valid
//   req_data      - packed data, requester i on [i*DATA_W +: DATA_W]
//   req_last      - final beat of a burst, qualified by req
//   gnt           - one-hot beat accept
//   fifo_full     - FIFO full flag
//   fifo_wrt_sig  - FIFO write strobe
//   fifo_din      - FIFO write data
//   owner         - current owner index, valid while busy
//   busy          - arbiter is in a burst
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned STALL_MAX = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      fifo_full,
  output logic                      fifo_wrt_sig,
  output logic [DATA_W-1:0]         fifo_din,
  output logic [clog2(NUM_REQ)-1:0] owner,
  output logic                      busy
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [DATA_W-1:0] lanes [NUM_REQ];
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              owner_req;
  logic              accept;
  logic [CNT_W-1:0]  beat_inc;
  logic [CNT_W-1:0]  stall_inc;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lanes
    assign lanes[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .index (pick_idx)
  );

  assign owner_req = req[owner_q];
  assign accept    = (state_q == StBurst) && owner_req && !fifo_full;
  assign beat_inc  = beat_cnt_q + 8'd1;
  assign stall_inc = stall_cnt_q + 8'd1;

  // Beat path: everything is zero outside an accepted beat, so a reset
  // (which forces StIdle) immediately clears the outputs.
  always_comb begin
    gnt          = '0;
    fifo_wrt_sig = accept;
    fifo_din     = '0;
    if (accept) begin
      gnt[owner_q] = 1'b1;
      fifo_din     = lanes[owner_q];
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q == StBurst);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StBurst;
          owner_d = pick_idx;
        end
      end
      StBurst: begin
        if (accept) begin
          beat_cnt_d  = beat_inc;
          stall_cnt_d = '0;
          // last and the burst cap may coincide; either one gives a single exit
          if (req_last[owner_q] || (beat_inc == CNT_W'(BURST_MAX))) begin
            state_d     = StIdle;
            rr_ptr_d    = owner_q;
            beat_cnt_d  = '0;
          end
        end else if (!owner_req) begin
          // Only an absent owner counts as a stall; a full FIFO does not.
          stall_cnt_d = stall_inc;
          if (stall_inc == CNT_W'(STALL_MAX)) begin
            state_d     = StIdle;
            rr_ptr_d    = owner_q;
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8, BURST_MAX=4,
// STALL_MAX=8). Per-cycle vectors are driven on the falling edge and the
// outputs compared 1 ns later; an asynchronous reset sequence is hand-written.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_wrt_sig;
  logic [7:0]  fifo_din;
  logic [1:0]  owner;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .BURST_MAX (4),
    .STALL_MAX (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .req_last     (req_last),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_wrt_sig (fifo_wrt_sig),
    .fifo_din     (fifo_din),
    .owner        (owner),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic        full;
    logic [3:0]  e_gnt;
    logic [7:0]  e_din;
    logic [1:0]  e_owner;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic v_rst(input logic [3:0] r);
    vecs.push_back('{1'b1, r, 32'h0, 4'h0, 1'b0, 4'h0, 8'h0, 2'd0, 1'b0});
  endtask

  task automatic v_idle(input logic [3:0] r, input logic [31:0] d, input logic [3:0] l);
    vecs.push_back('{1'b0, r, d, l, 1'b0, 4'h0, 8'h0, 2'd0, 1'b0});
  endtask

  task automatic v_busy(input logic [3:0] r, input logic [31:0] d, input logic [3:0] l,
                        input logic f, input logic [3:0] g, input logic [7:0] dn,
                        input logic [1:0] o);
    vecs.push_back('{1'b0, r, d, l, f, g, dn, o, 1'b1});
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
    repeat (2) @(negedge clk);

    // reset state with requests present
    v_rst(4'b1111);
    // single requester 2, three beats, last on the third
    v_idle(4'b0100, 32'h00A10000, 4'h0);
    v_busy(4'b0100, 32'h00A10000, 4'h0, 1'b0, 4'b0100, 8'hA1, 2'd2);
    v_busy(4'b0100, 32'h00A20000, 4'h0, 1'b0, 4'b0100, 8'hA2, 2'd2);
    v_busy(4'b0100, 32'h00A30000, 4'b0100, 1'b0, 4'b0100, 8'hA3, 2'd2);
    v_idle(4'b0000, 32'h0, 4'h0);
    // round robin from reset: 0,1,2,3,0 with an idle cycle between grants
    v_rst(4'b0000);
    for (int k = 0; k < 5; k++) begin
      v_idle(4'b1111, 32'hB3B2B1B0, 4'b1111);
      v_busy(4'b1111, 32'hB3B2B1B0, 4'b1111, 1'b0, 4'b0001 << (k % 4),
             8'hB0 + 8'(k % 4), 2'(k % 4));
    end
    v_idle(4'b0000, 32'h0, 4'h0);
    // burst cap: six beats from requester 1 without last, cut after four
    v_idle(4'b0010, 32'h0000C100, 4'h0);
    for (int k = 1; k <= 4; k++)
      v_busy(4'b0010, 32'h0000C000 | (k << 8), 4'h0, 1'b0, 4'b0010, 8'hC0 + 8'(k), 2'd1);
    v_idle(4'b0010, 32'h0000C500, 4'h0);
    v_busy(4'b0010, 32'h0000C500, 4'h0, 1'b0, 4'b0010, 8'hC5, 2'd1);
    v_busy(4'b0010, 32'h0000C600, 4'b0010, 1'b0, 4'b0010, 8'hC6, 2'd1);
    v_idle(4'b0000, 32'h0, 4'h0);
    // full backpressure for 5 cycles, then 4 idle-owner cycles: 9 total
    // must not be counted as a stall timeout
    v_idle(4'b0001, 32'h000000D1, 4'h0);
    v_busy(4'b0001, 32'h000000D1, 4'h0, 1'b0, 4'b0001, 8'hD1, 2'd0);
    for (int k = 0; k < 5; k++)
      v_busy(4'b0001, 32'h000000D2, 4'h0, 1'b1, 4'h0, 8'h0, 2'd0);
    for (int k = 0; k < 4; k++)
      v_busy(4'b0000, 32'h000000D2, 4'h0, 1'b0, 4'h0, 8'h0, 2'd0);
    v_busy(4'b0001, 32'h000000D2, 4'b0001, 1'b0, 4'b0001, 8'hD2, 2'd0);
    v_idle(4'b0000, 32'h0, 4'h0);
    // stall timeout: owner 3 drops req after one beat while req[0] waits
    v_idle(4'b1001, 32'hE30000E0, 4'h0);
    v_busy(4'b1001, 32'hE30000E0, 4'h0, 1'b0, 4'b1000, 8'hE3, 2'd3);
    for (int k = 0; k < 8; k++)
      v_busy(4'b0001, 32'hE30000E0, 4'h0, 1'b0, 4'h0, 8'h0, 2'd3);
    v_idle(4'b0001, 32'hE30000E0, 4'h0);
    v_busy(4'b0001, 32'hE30000E0, 4'b0001, 1'b0, 4'b0001, 8'hE0, 2'd0);
    v_idle(4'b0000, 32'h0, 4'h0);
    // accept after 7 stall cycles clears the stall count and keeps the burst
    v_idle(4'b0100, 32'h00F10000, 4'h0);
    v_busy(4'b0100, 32'h00F10000, 4'h0, 1'b0, 4'b0100, 8'hF1, 2'd2);
    for (int k = 0; k < 7; k++)
      v_busy(4'b0000, 32'h0, 4'h0, 1'b0, 4'h0, 8'h0, 2'd2);
    v_busy(4'b0100, 32'h00F20000, 4'h0, 1'b0, 4'b0100, 8'hF2, 2'd2);
    v_busy(4'b0000, 32'h0, 4'h0, 1'b0, 4'h0, 8'h0, 2'd2);
    v_busy(4'b0100, 32'h00F30000, 4'b0100, 1'b0, 4'b0100, 8'hF3, 2'd2);
    v_idle(4'b0000, 32'h0, 4'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; req = vecs[i].req; req_data = vecs[i].data;
      req_last = vecs[i].last; fifo_full = vecs[i].full;
      #1;
      check($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
      check($sformatf("v%0d wrt", i), 32'(fifo_wrt_sig), 32'(|vecs[i].e_gnt));
      check($sformatf("v%0d din", i), 32'(fifo_din), 32'(vecs[i].e_din));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_busy)
        check($sformatf("v%0d owner", i), 32'(owner), 32'(vecs[i].e_owner));
    end

    // asynchronous reset mid-burst, asserted between clock edges
    @(negedge clk);
    rst = 1'b1; req = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
    @(negedge clk);
    rst = 1'b0; req = 4'b0100; req_data = 32'h005A0000;
    @(negedge clk);
    #1;
    check("mid gnt before reset", 32'(gnt), 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check("async rst gnt", 32'(gnt), 32'h0);
    check("async rst wrt", 32'(fifo_wrt_sig), 32'h0);
    check("async rst busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0; req = 4'b0101; req_data = 32'h005A00A5;
    #1;
    check("post rst idle busy", 32'(busy), 32'h0);
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 4 && !got; c++) begin
        @(negedge clk);
        #1;
        if (gnt != 4'h0) got = 1'b1;
      end
      check("post rst grant seen", 32'(got), 32'h1);
      check("post rst gnt", 32'(gnt), 32'h1);
      check("post rst din", 32'(fifo_din), 32'hA5);
    end
    @(negedge clk);
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
